// File: rtl/run_ctrl.sv
// Simulation run controller: counts enabled RUN cycles and per-channel events,
// then settles into an absorbing PASS or FAIL state with a one-cycle done pulse.
module run_ctrl #(
    parameter int WIDTH      = 32,
    parameter int NCH        = 4,
    parameter int EV_WIDTH   = 8,
    parameter int EV_TARGET  = 4,
    parameter int TERM_COUNT = 3,
    parameter int TIMEOUT    = 100,
    parameter int MODE       = 0
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             enable,
    input  logic [NCH-1:0]   event_i,
    output logic [WIDTH-1:0] count_o,
    output logic [NCH-1:0]   ev_seen_o,
    output logic [1:0]       state_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]    TERM_W = WIDTH'(TERM_COUNT);
    localparam logic [WIDTH-1:0]    TMO_W  = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0]    MAX_W  = (TERM_COUNT > TIMEOUT) ? TERM_W : TMO_W;
    localparam logic [EV_WIDTH-1:0] EV_TGT = EV_WIDTH'(EV_TARGET);

    state_t              r_state;
    state_t              w_next;
    logic [WIDTH-1:0]    r_count;
    logic [EV_WIDTH-1:0] r_ev_cnt [NCH];
    logic                r_done;
    logic                w_run_en;
    logic                w_pass_cond;
    logic                w_timeout;

    // Decisions use registered values only; events landing this edge count next cycle.
    assign w_run_en    = (r_state == S_RUN) && enable;
    assign w_pass_cond = (MODE == 1) ? (&ev_seen_o) : (r_count >= TERM_W);
    assign w_timeout   = (r_count >= TMO_W);

    always_ff @(posedge clk) begin
        if (!reset_l) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (enable) w_next = S_RUN;
            S_RUN: begin
                if (enable) begin
                    if (w_pass_cond)    w_next = S_PASS;
                    else if (w_timeout) w_next = S_FAIL;
                end
            end
            default: w_next = r_state;
        endcase
    end

    always_comb begin
        state_o = r_state;
        busy_o  = (r_state == S_RUN);
        pass_o  = (r_state == S_PASS);
        fail_o  = (r_state == S_FAIL);
        done_o  = r_done;
        count_o = r_count;
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == S_RUN) && (w_next != S_RUN);
            if (w_run_en && (w_next == S_RUN))
                r_count <= r_count + WIDTH'(1);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        always_ff @(posedge clk) begin
            if (!reset_l)
                r_ev_cnt[g] <= '0;
            else if (w_run_en && event_i[g] && (r_ev_cnt[g] != EV_TGT))
                r_ev_cnt[g] <= r_ev_cnt[g] + EV_WIDTH'(1);
        end
        // Counter saturates at the target, so equality is a sticky flag.
        assign ev_seen_o[g] = (r_ev_cnt[g] == EV_TGT);
    end

    a_excl:  assert property (@(posedge clk) !(pass_o && fail_o));
    a_done:  assert property (@(posedge clk) done_o |-> (pass_o || fail_o));
    a_max:   assert property (@(posedge clk) count_o <= MAX_W);
    c_pass:  cover property (@(posedge clk) r_state == S_PASS);
    c_fail:  cover property (@(posedge clk) r_state == S_FAIL);
    c_both:  cover property (@(posedge clk) w_run_en && w_pass_cond && w_timeout);

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: three instances (cycle mode, event mode, short
// timeout event mode) driven together and checked against a spec-level model.
module tb_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       en = 1'b0;
    logic [3:0] ev = 4'h0;

    logic [31:0] cnt  [3];
    logic [3:0]  seen [3];
    logic [1:0]  st   [3];
    logic        busy [3];
    logic        done [3];
    logic        pass [3];
    logic        fail [3];

    always #5 clk = ~clk;

    run_ctrl #(.MODE(0)) u0 (
        .clk(clk), .reset_l(rst_l), .enable(en), .event_i(ev),
        .count_o(cnt[0]), .ev_seen_o(seen[0]), .state_o(st[0]), .busy_o(busy[0]),
        .done_o(done[0]), .pass_o(pass[0]), .fail_o(fail[0]));
    run_ctrl #(.MODE(1)) u1 (
        .clk(clk), .reset_l(rst_l), .enable(en), .event_i(ev),
        .count_o(cnt[1]), .ev_seen_o(seen[1]), .state_o(st[1]), .busy_o(busy[1]),
        .done_o(done[1]), .pass_o(pass[1]), .fail_o(fail[1]));
    run_ctrl #(.MODE(1), .TIMEOUT(10)) u2 (
        .clk(clk), .reset_l(rst_l), .enable(en), .event_i(ev),
        .count_o(cnt[2]), .ev_seen_o(seen[2]), .state_o(st[2]), .busy_o(busy[2]),
        .done_o(done[2]), .pass_o(pass[2]), .fail_o(fail[2]));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase 0 idle, 1 running, 2 passed, 3 failed; events per channel as plain ints.
    int m_mode [3] = '{0, 1, 1};
    int m_term [3] = '{3, 3, 3};
    int m_tmo  [3] = '{100, 100, 10};
    int m_st   [3];
    int m_cnt  [3];
    int m_evc  [3][4];
    bit m_done [3];
    bit m_valid = 1'b0;

    function automatic logic [3:0] m_seen(input int d);
        logic [3:0] s;
        for (int k = 0; k < 4; k++) s[k] = (m_evc[d][k] >= 4);
        return s;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_l) begin
                m_st[d] = 0; m_cnt[d] = 0; m_done[d] = 1'b0;
                for (int k = 0; k < 4; k++) m_evc[d][k] = 0;
            end else begin
                m_done[d] = 1'b0;
                if (m_st[d] == 0 && en) begin
                    m_st[d] = 1;
                end else if (m_st[d] == 1 && en) begin
                    bit pc, to;
                    pc = (m_mode[d] == 1) ? (m_seen(d) == 4'hF) : (m_cnt[d] >= m_term[d]);
                    to = (m_cnt[d] >= m_tmo[d]);
                    for (int k = 0; k < 4; k++)
                        if (ev[k] && m_evc[d][k] < 4) m_evc[d][k]++;
                    if (pc)      begin m_st[d] = 2; m_done[d] = 1'b1; end
                    else if (to) begin m_st[d] = 3; m_done[d] = 1'b1; end
                    else         m_cnt[d]++;
                end
            end
        end
        if (!rst_l) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (st[d] !== 2'(m_st[d]) || cnt[d] !== 32'(m_cnt[d]) || seen[d] !== m_seen(d) ||
                    busy[d] !== (m_st[d] == 1) || pass[d] !== (m_st[d] == 2) ||
                    fail[d] !== (m_st[d] == 3) || done[d] !== m_done[d]) begin
                    n_bad++;
                    $display("FAIL model u%0d t=%0t: got st=%0d cnt=%0d seen=%h b/d/p/f=%b%b%b%b, want st=%0d cnt=%0d seen=%h done=%b",
                             d, $time, st[d], cnt[d], seen[d], busy[d], done[d], pass[d], fail[d],
                             m_st[d], m_cnt[d], m_seen(d), m_done[d]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic e, input logic [3:0] v);
        en = e; ev = v;
        @(posedge clk); #1;
    endtask

    task automatic rst_tick();
        rst_l = 1'b0; en = 1'b0; ev = 4'h0;
        @(posedge clk); #1;
        rst_l = 1'b1;
    endtask

    // Constant-enable MODE 0 run: RUN after edge 1, PASS after edge 5.
    task automatic seq_basic(input string tag);
        tick(1, 0);
        chk({tag, "_run_state"}, st[0], 1);
        chk({tag, "_run_cnt"}, cnt[0], 0);
        for (int i = 1; i <= 3; i++) begin
            tick(1, 0);
            chk({tag, "_cnt"}, cnt[0], i);
        end
        tick(1, 0);
        chk({tag, "_pass_state"}, st[0], 2);
        chk({tag, "_pass_done"}, done[0], 1);
        chk({tag, "_pass_cnt"}, cnt[0], 3);
        tick(1, 0);
        chk({tag, "_done_clear"}, done[0], 0);
        chk({tag, "_pass_level"}, pass[0], 1);
    endtask

    initial begin
        // Scenario 1
        rst_tick(); rst_tick();
        chk("reset_state", st[0], 0);
        chk("reset_cnt", cnt[0], 0);
        chk("reset_busy", busy[0], 0);
        seq_basic("s1");

        // Scenario 6: reset mid-RUN, IDLE ignores events, rerun, reset in PASS
        rst_tick();
        tick(1, 0); tick(1, 4'hF); tick(1, 0);
        chk("s6_mid_cnt", cnt[0], 2);
        rst_tick();
        chk("s6_rst_state", st[1], 0);
        chk("s6_rst_cnt", cnt[1], 0);
        chk("s6_rst_seen", seen[1], 0);
        tick(0, 4'hF);
        chk("s6_idle_hold", st[0], 0);
        chk("s6_idle_seen", seen[2], 0);
        seq_basic("s6");
        rst_tick();
        chk("s6_pass_rst_state", st[0], 0);
        chk("s6_pass_rst_flags", {done[0], pass[0], fail[0], busy[0]}, 0);

        // Scenario 2: enable toggling, events offered only on disabled cycles
        rst_tick();
        tick(1, 0);
        for (int i = 0; i < 6; i++) tick((i % 2) == 0, (i % 2) ? 4'hF : 4'h0);
        chk("s2_pre_state", st[0], 1);
        chk("s2_pre_cnt", cnt[0], 3);
        chk("s2_no_events", seen[1], 0);
        tick(1, 0);
        chk("s2_pass", st[0], 2);
        chk("s2_cnt", cnt[0], 3);

        // Scenario 3: staggered events fill all channels
        rst_tick();
        tick(1, 0);
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) tick(1, 4'(1 << k));
        chk("s3_seen", seen[1], 4'hF);
        chk("s3_still_run", st[1], 1);
        chk("s3_cnt", cnt[1], 16);
        tick(1, 0);
        chk("s3_pass", st[1], 2);
        chk("s3_done", done[1], 1);
        chk("s3_pass_cnt", cnt[1], 16);
        tick(1, 0);
        chk("s3_done_once", done[1], 0);
        chk("s3_short_tmo_fail", st[2], 3);
        chk("s3_short_tmo_cnt", cnt[2], 10);

        // Scenario 4: channel 2 one event short -> timeout
        rst_tick();
        tick(1, 0);
        tick(1, 4'hF); tick(1, 4'hF); tick(1, 4'hF); tick(1, 4'hB);
        chk("s4_seen", seen[1], 4'hB);
        for (int i = 0; i < 200 && st[1] != 2'd3; i++) tick(1, 0);
        chk("s4_fail_state", st[1], 3);
        chk("s4_fail_cnt", cnt[1], 100);
        chk("s4_fail_o", fail[1], 1);
        chk("s4_pass_o", pass[1], 0);

        // Scenario 5: all channels complete exactly as count reaches the timeout
        rst_tick();
        tick(1, 0);
        for (int i = 0; i < 3; i++) tick(1, 4'hF);
        for (int i = 0; i < 6; i++) tick(1, 4'h0);
        tick(1, 4'hF);
        chk("s5_seen", seen[2], 4'hF);
        chk("s5_cnt", cnt[2], 10);
        chk("s5_run", st[2], 1);
        tick(1, 0);
        chk("s5_pass_priority", st[2], 2);
        chk("s5_pass_cnt", cnt[2], 10);
        chk("s5_flags", {pass[2], fail[2], done[2]}, 3'b101);

        tick(0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Parametrised simulation run controller that succeeds the single fixed-limit example counter. It counts enabled cycles and declares the run PASS or FAIL.
- MODE 0: PASS on reaching a cycle terminal count.
- MODE 1: PASS when all NCH event channels have each hit a target count before a cycle timeout.
It sits beside the DUT in example/test tops and drives the harness end-of-test decision through sticky pass/fail flags and a done pulse.

Parameters:
- WIDTH, 32: cycle counter width; requires TERM_COUNT and TIMEOUT < 2**WIDTH.
- NCH, 4: number of event channels, >=1.
- EV_WIDTH, 8: per-channel event counter width.
- EV_TARGET, 4: events required per channel, 1..2**EV_WIDTH-1.
- TERM_COUNT, 3: MODE 0 pass threshold on count_o.
- TIMEOUT, 100: fail threshold on count_o, applies in both modes.
- MODE, 0: 0 = cycle-count completion; 1 = event-driven completion.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset_l  in  1  synchronous, active-low reset.
- enable  in  1  advance counters and FSM evaluation when high.
- event_i  in  NCH  per-channel event strobe, sampled on enabled RUN cycles.
- count_o  out  WIDTH  enabled RUN cycles elapsed.
- ev_seen_o  out  NCH  bit k high once channel k count == EV_TARGET; sticky.
- state_o  out  2  encoding: 0 IDLE, 1 RUN, 2 PASS, 3 FAIL.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse on entry to PASS or FAIL.
- pass_o  out  1  high while in PASS.
- fail_o  out  1  high while in FAIL.

Behaviour:
- Reset is synchronous and active-low: reset_l low at a rising edge sets state IDLE and clears count_o, all channel counters, ev_seen_o, done_o, pass_o, fail_o and busy_o. This applies from any state, including mid-RUN and terminal states.
- IDLE:
  - enable=1 → RUN at the next edge; count_o stays 0.
  - event_i is ignored.
- RUN, enable=0: every register holds and no transition occurs.
- RUN, enable=1, evaluated on current registered values:
  - pass_cond: MODE 0 → count_o >= TERM_COUNT; MODE 1 → &ev_seen_o.
  - timeout_cond: count_o >= TIMEOUT.
  - pass_cond → PASS (pass has priority when pass_cond and timeout_cond coincide).
  - else timeout_cond → FAIL.
  - else count_o <= count_o + 1.
- count_o holds its value on the transition edge.
- Event counters (RUN and enable=1 only):
  - Channel k increments when event_i[k]=1, saturating at EV_TARGET.
  - ev_seen_o[k] sets on the edge the counter reaches EV_TARGET.
  - Events arriving on the transition edge still update the counters; they do not affect the decision, which sees the registered ev_seen_o one cycle later.
- Mode dependence:
  - In MODE 0, event counters still run; only ev_seen_o is observable.
  - In MODE 1, TERM_COUNT is unused.
- PASS and FAIL:
  - Absorbing until reset; counters frozen; enable and event_i ignored.
  - done_o=1 only in the first cycle of the terminal state.
  - pass_o and fail_o are levels tied to state.
- Embedded checks (simulation):
  - Assertion: never pass_o && fail_o.
  - Assertion: done_o implies pass_o || fail_o.
  - Assertion: count_o never exceeds max(TERM_COUNT, TIMEOUT).
  - Cover: PASS reached; FAIL reached; simultaneous pass_cond and timeout_cond.

Test Plan:
1. MODE 0, TERM_COUNT=3, reset_l low 2 edges then high, enable=1 constant → RUN after edge 1; count_o 1,2,3 after edges 2,3,4; PASS, done_o=1 and count_o=3 after edge 5; done_o=0 from edge 6 on.
2. MODE 0, enable toggled 1,0,1,0… from RUN → count_o advances only on enable=1 edges; PASS on the 4th enabled RUN edge; count_o=3.
3. MODE 1, NCH=4, EV_TARGET=4, TIMEOUT=100, 4 pulses per channel staggered → ev_seen_o fills to 4'hF; PASS one enabled edge later with count_o < 100; done_o pulses once.
4. MODE 1, channel 2 receives only 3 events → ev_seen_o=4'hB; FAIL when count_o=100; fail_o=1, pass_o=0.
5. MODE 1, TIMEOUT=10, last event arranged so &ev_seen_o first holds at count_o=10 → PASS, not FAIL (pass priority).
6. reset_l low for one edge at count_o=2 mid-RUN, and again in PASS → next cycle state IDLE, count_o=0, ev_seen_o=0, flags 0; a rerun repeats the scenario 1 timing.
